uart_tx_fifo: RTL and testbench

Transmit-side elastic buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the bus/register side through a valid/ready handshake.
- Presents them first-word-fall-through to the transmitter's tx_valid/tx_data/tx_ready interface.
- Reports fill level, a programmable low-watermark interrupt, and a sticky overflow flag for the CSR block.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_tx_fifo.sv | 90 +++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register array, one write port, async read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; readers gate the output on occupancy.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FWFT transmit elastic buffer with level, low-watermark irq and sticky overflow
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_flush,
  input  logic [AW:0]            cfg_thresh,
  input  logic                   wr_valid,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   wr_ovf,
  output logic                   tx_valid,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_ready,
  output logic [AW:0]            level,
  output logic                   empty,
  output logic                   full,
  output logic                   irq_txlow,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0]            wptr_q, wptr_d;
  logic [AW:0]            rptr_q, rptr_d;
  logic [AW:0]            level_d;
  logic                   irq_q;
  logic                   ovf_q, ovf_d;
  logic                   push, pop;
  logic [UART_DATA_W-1:0] mem_rdata;

  assign level    = wptr_q - rptr_q;
  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign wr_ready = ~full;
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : mem_rdata;

  // A flush cancels both the push and the pop issued in the same cycle.
  assign push = ((wr_valid & wr_ready) | (wr_ovf & ~full)) & ~cfg_flush;
  assign pop  = tx_valid & tx_ready & ~cfg_flush;

  always_comb begin
    wptr_d  = wptr_q + (AW+1)'(push);
    rptr_d  = cfg_flush ? wptr_q : rptr_q + (AW+1)'(pop);
    level_d = wptr_d - rptr_d;
    ovf_d   = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (full & (wr_valid | wr_ovf)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      irq_q  <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      irq_q  <= (level_d <= cfg_thresh);
      ovf_q  <= ovf_d;
    end
  end

  assign irq_txlow  = irq_q;
  assign ovf_sticky = ovf_q;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_flush;
  logic [4:0] cfg_thresh;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_ovf;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       irq_txlow;
  logic       ovf_sticky;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_flush  (cfg_flush),
    .cfg_thresh (cfg_thresh),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_ovf     (wr_ovf),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .irq_txlow  (irq_txlow),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b0;
    cfg_flush  = 1'b0;
    cfg_thresh = 5'd0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    wr_ovf     = 1'b0;
    tx_ready   = 1'b0;
    ovf_clr    = 1'b0;
    step();
    step();
    chk("rst_level", level, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", irq_txlow, 1);
    rst = 1'b1;
    step();

    chk("idle_empty", empty, 1);
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_tx_valid", tx_valid, 0);
    chk("idle_level", level, 0);
    chk("idle_irq", irq_txlow, 1);
    chk("idle_full", full, 0);
    chk("idle_ovf", ovf_sticky, 0);

    // Fill 0x00..0x0F with the transmitter busy
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
      chk("fill_level", level, i + 1);
    end
    wr_valid = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_irq", irq_txlow, 0);
    chk("fill_head", tx_data, 8'h00);

    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    step();
    wr_valid = 1'b0;
    chk("ovf_set", ovf_sticky, 1);
    chk("ovf_level", level, 16);
    wr_ovf  = 1'b1;
    ovf_clr = 1'b1;
    step();
    wr_ovf = 1'b0;
    chk("ovf_set_beats_clr", ovf_sticky, 1);
    chk("ovf_force_level", level, 16);
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf_sticky, 0);

    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", tx_valid, 1);
      chk("drain_data", tx_data, i);
      step();
    end
    tx_ready = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_tx_valid", tx_valid, 0);
    chk("drain_irq", irq_txlow, 1);

    // Pointers now at index 0: load 9, pop 4 -> level 5 at read index 4
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h20 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pre_pop_data", tx_data, 8'h20 + i);
      step();
    end
    chk("pre_level", level, 5);

    for (int k = 0; k < 10; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h30 + 8'(k);
      chk("pp_data", tx_data, (k < 5) ? (8'h24 + k) : (8'h30 + k - 5));
      step();
      chk("pp_level", level, 5);
    end
    wr_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("wrap_data", tx_data, 8'h35 + j);
      step();
    end
    tx_ready = 1'b0;
    chk("wrap_empty", empty, 1);

    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h60 + 8'(i);
      step();
    end
    chk("flush_pre_level", level, 7);
    wr_data   = 8'h55;
    cfg_flush = 1'b1;
    tx_ready  = 1'b1;
    step();
    cfg_flush = 1'b0;
    wr_valid  = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_tx_valid", tx_valid, 0);
    chk("flush_irq", irq_txlow, 1);
    step();
    chk("flush_discard", tx_valid, 0);
    tx_ready = 1'b0;

    // Watermark at 1 with a transmitter that raises tx_ready for one cycle per byte
    cfg_thresh = 5'd1;
    wr_ovf     = 1'b1;
    wr_data    = 8'h41;
    step();
    wr_ovf = 1'b0;
    chk("wm_force_level", level, 1);
    chk("wm_irq_at_1", irq_txlow, 1);
    wr_valid = 1'b1;
    wr_data  = 8'h42;
    step();
    wr_valid = 1'b0;
    chk("wm_level2", level, 2);
    chk("wm_irq_low", irq_txlow, 0);
    chk("wm_head", tx_data, 8'h41);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("wm_pop1_level", level, 1);
    chk("wm_irq_rise", irq_txlow, 1);
    step();
    step();
    chk("wm_hold_level", level, 1);
    chk("wm_head2", tx_data, 8'h42);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("wm_pop2_level", level, 0);

    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h90 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    chk("mid_level", level, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_tx_data", tx_data, 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_wr_ready", wr_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
